// File: rtl/feature_wr_dma.sv
// Write-back DMA: streams pixel words into DDR as [ch_grp][h][w] through an AXI4 write master.
// Each output line is split into INCR bursts of at most BURST_MAX beats.
//
// state  | meaning
// IDLE   | waiting for start, config not yet captured
// AW     | presenting the address/length of the next burst
// W      | passing pixel beats straight through to the W channel
// WAITB  | all data sent, draining outstanding write responses
// DONE   | one-cycle completion pulse
module feature_wr_dma #(
  parameter int AXI_DW    = 256,
  parameter int ADDR_W    = 32,
  parameter int ID_W      = 4,
  parameter int BURST_MAX = 16,
  parameter int CNT_W     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   cfg_base,
  input  logic [ADDR_W-1:0]   cfg_surf_stride,
  input  logic [ADDR_W-1:0]   cfg_line_stride,
  input  logic [CNT_W-1:0]    cfg_w,
  input  logic [CNT_W-1:0]    cfg_h,
  input  logic [CNT_W-1:0]    cfg_chg,
  output logic                busy,
  output logic                done,
  output logic                err,
  input  logic [AXI_DW-1:0]   s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic [ID_W-1:0]     m_awid,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic [7:0]          m_awlen,
  output logic [2:0]          m_awsize,
  output logic [1:0]          m_awburst,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [AXI_DW-1:0]   m_wdata,
  output logic [AXI_DW/8-1:0] m_wstrb,
  output logic                m_wlast,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic [ID_W-1:0]     m_bid,
  input  logic [1:0]          m_bresp,
  input  logic                m_bvalid,
  output logic                m_bready
);

  localparam int PIX_BYTES = AXI_DW / 8;
  localparam int PIX_SH    = $clog2(PIX_BYTES);

  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_WAITB, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    w_q, h_q, chg_q;
  logic [CNT_W-1:0]    w_idx_q, h_idx_q, cg_idx_q;
  logic [ADDR_W-1:0]   surf_stride_q, line_stride_q;
  logic [ADDR_W-1:0]   surf_ptr_q, line_addr_q;
  logic [7:0]          len_q, beat_q;
  logic [15:0]         outst_q;
  logic                err_q;

  logic                aw_hs, w_hs, b_hs;
  logic [CNT_W-1:0]    rem, w_idx_inc, h_idx_inc, cg_idx_inc;
  logic [ADDR_W-1:0]   aw_addr_c;
  logic [7:0]          aw_len_c;
  logic                wlast_c, row_end, surf_end, job_end, cfg_empty;
  logic                unused_bid;

  assign unused_bid = ^m_bid;

  assign rem        = w_q - w_idx_q;
  assign aw_len_c   = (rem >= CNT_W'(BURST_MAX)) ? 8'(BURST_MAX - 1) : 8'(rem - 1'b1);
  assign aw_addr_c  = line_addr_q + (ADDR_W'(w_idx_q) << PIX_SH);
  assign wlast_c    = (beat_q == len_q);
  assign w_idx_inc  = w_idx_q + 1'b1;
  assign h_idx_inc  = h_idx_q + 1'b1;
  assign cg_idx_inc = cg_idx_q + 1'b1;
  assign row_end    = (w_idx_inc == w_q);
  assign surf_end   = (h_idx_inc == h_q);
  assign job_end    = (cg_idx_inc == chg_q);
  assign cfg_empty  = (cfg_w == '0) || (cfg_h == '0) || (cfg_chg == '0);

  assign aw_hs = m_awvalid && m_awready;
  assign w_hs  = m_wvalid && m_wready;
  assign b_hs  = m_bvalid && m_bready;

  assign m_awid    = '0;
  assign m_awsize  = 3'(PIX_SH);
  assign m_awburst = 2'b01;
  assign m_wstrb   = '1;
  assign m_bready  = 1'b1;
  assign err       = err_q;

  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    done      = 1'b0;
    s_ready   = 1'b0;
    m_awvalid = 1'b0;
    m_awaddr  = '0;
    m_awlen   = '0;
    m_wvalid  = 1'b0;
    m_wdata   = '0;
    m_wlast   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Empty jobs drain through WAITB so their done timing matches a real job's tail.
        if (start) state_d = cfg_empty ? S_WAITB : S_AW;
      end
      S_AW: begin
        busy      = 1'b1;
        m_awvalid = 1'b1;
        m_awaddr  = aw_addr_c;
        m_awlen   = aw_len_c;
        if (aw_hs) state_d = S_W;
      end
      S_W: begin
        busy     = 1'b1;
        m_wvalid = s_valid;
        s_ready  = m_wready;
        m_wdata  = s_data;
        m_wlast  = wlast_c;
        if (w_hs && wlast_c)
          state_d = (row_end && surf_end && job_end) ? S_WAITB : S_AW;
      end
      S_WAITB: begin
        busy = 1'b1;
        if (outst_q == '0 || (outst_q == 16'd1 && b_hs)) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      w_q           <= '0;
      h_q           <= '0;
      chg_q         <= '0;
      w_idx_q       <= '0;
      h_idx_q       <= '0;
      cg_idx_q      <= '0;
      surf_stride_q <= '0;
      line_stride_q <= '0;
      surf_ptr_q    <= '0;
      line_addr_q   <= '0;
      len_q         <= '0;
      beat_q        <= '0;
      outst_q       <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q <= state_d;

      if (aw_hs) begin
        len_q  <= m_awlen;
        beat_q <= '0;
      end

      if (w_hs) begin
        beat_q <= beat_q + 8'd1;
        if (wlast_c && row_end) begin
          w_idx_q <= '0;
          if (surf_end) begin
            // Surface pointer accumulates the stride instead of multiplying ch_grp.
            h_idx_q     <= '0;
            cg_idx_q    <= cg_idx_inc;
            surf_ptr_q  <= surf_ptr_q + surf_stride_q;
            line_addr_q <= surf_ptr_q + surf_stride_q;
          end else begin
            h_idx_q     <= h_idx_inc;
            line_addr_q <= line_addr_q + line_stride_q;
          end
        end else begin
          w_idx_q <= w_idx_inc;
        end
      end

      case ({aw_hs, b_hs})
        2'b10:   outst_q <= outst_q + 16'd1;
        2'b01:   outst_q <= outst_q - 16'd1;
        default: outst_q <= outst_q;
      endcase

      if (b_hs && m_bresp != 2'b00) err_q <= 1'b1;

      if (state_q == S_IDLE && start) begin
        w_q           <= cfg_w;
        h_q           <= cfg_h;
        chg_q         <= cfg_chg;
        surf_stride_q <= cfg_surf_stride;
        line_stride_q <= cfg_line_stride;
        surf_ptr_q    <= cfg_base;
        line_addr_q   <= cfg_base;
        w_idx_q       <= '0;
        h_idx_q       <= '0;
        cg_idx_q      <= '0;
        err_q         <= 1'b0;
      end
    end
  end

endmodule
